shift_cmd_seq: RTL

SHIFT_CMD_SEQ -- requirements
Module: shift_cmd_seq

---
 rtl/shift_cmd_pkg.sv | 22 ++
 rtl/shift_cmd_fifo.sv | 68 ++++++
 rtl/shift_cmd_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/shift_cmd_pkg.sv
// Shared types and defaults for the shift-register command sequencer.
// Holds the FIFO entry layout, FSM states and the idle direction code.
package shift_cmd_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DIR_W_DEF  = 3;
    localparam int CNT_W_DEF  = 4;

    localparam logic [2:0] DIR_IDLE = 3'b000;

    typedef struct packed {
        logic [DIR_W_DEF-1:0]  dir;
        logic [DATA_W_DEF-1:0] data;
        logic [CNT_W_DEF-1:0]  count;
    } cmd_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/shift_cmd_fifo.sv
// Synchronous command FIFO with registered empty and not-full flags.
// Entries are flat {dir, data, count} words; flush clears it in one edge.
module shift_cmd_fifo #(
    parameter int W     = 15,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         empty_nxt,
    output logic         ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (flush) begin
            cnt_nxt = '0;
        end else if (push && !pop) begin
            cnt_nxt = cnt + CW'(1);
        end else if (pop && !push) begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    assign empty_nxt = (cnt_nxt == '0);
    assign rdata     = mem[rd_ptr];

    // Ready stays low through reset and rises on the first live edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            empty  <= 1'b1;
            ready  <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            empty <= (cnt_nxt == '0);
            ready <= (cnt_nxt != CW'(DEPTH));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/shift_cmd_seq.sv
// Command sequencer: queues {dir, data, count} commands and replays each
// one on the shift register control pins for count+1 cycles.
module shift_cmd_seq
    import shift_cmd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIR_W  = DIR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DIR_W-1:0]  cmd_dir,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              flush,
    output logic              enable,
    output logic [DATA_W-1:0] data_in,
    output logic [DIR_W-1:0]  shift_direction,
    output logic              busy,
    output logic              done
);

    localparam int W = DIR_W + DATA_W + CNT_W;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   rem;
    logic               push;
    logic               pop;
    logic               load;
    logic               empty;
    logic               empty_nxt;
    logic [W-1:0]       head;
    logic [DIR_W-1:0]   h_dir;
    logic [DATA_W-1:0]  h_data;
    logic [CNT_W-1:0]   h_count;

    assign push = cmd_valid && cmd_ready && !flush;
    assign {h_dir, h_data, h_count} = head;

    shift_cmd_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .wdata     ({cmd_dir, cmd_data, cmd_count}),
        .rdata     (head),
        .empty     (empty),
        .empty_nxt (empty_nxt),
        .ready     (cmd_ready)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Chain the next command on the last cycle to avoid a gap.
                if (rem == '0) begin
                    if (!empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
            pop       = 1'b0;
            load      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            rem             <= '0;
            enable          <= 1'b0;
            data_in         <= '0;
            shift_direction <= DIR_W'(DIR_IDLE);
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_ISSUE) || !empty_nxt;
            if (load) begin
                enable          <= 1'b1;
                data_in         <= h_data;
                shift_direction <= h_dir;
                rem             <= h_count;
                done            <= (h_count == '0);
            end else if (state_nxt == S_ISSUE) begin
                rem  <= rem - CNT_W'(1);
                done <= (rem == CNT_W'(1));
            end else begin
                enable          <= 1'b0;
                data_in         <= '0;
                shift_direction <= DIR_W'(DIR_IDLE);
                rem             <= '0;
                done            <= 1'b0;
            end
        end
    end

endmodule
